// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for the immediate generator: instruction in, decoded entry out.
// Timing is owned by imm_gen_pipe; this interface only groups the signals.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    parameter int CNT_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instruction;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   imm;
    logic [2:0]        fmt;
    logic              illegal;
    logic [TAG_W-1:0]  out_tag;
    logic [CNT_W-1:0]  illegal_cnt;

    modport master (
        output in_valid, instruction, in_tag, out_ready,
        input  in_ready, out_valid, imm, fmt, illegal, out_tag, illegal_cnt
    );

    modport slave (
        input  in_valid, instruction, in_tag, out_ready,
        output in_ready, out_valid, imm, fmt, illegal, out_tag, illegal_cnt
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// RV32 immediate decode into a 2-entry FIFO, with a saturating illegal-opcode counter.
// Latency: accepted at edge N, visible in cycle N+1; one instruction per cycle when unstalled.
// Backpressure: in_ready drops when both entries are full; it depends on registered occupancy only.

module imm_gen_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_vld_i,
    input  logic [W-1:0] wr_dat_i,
    output logic         full_o,
    output logic         rd_vld_o,
    input  logic         rd_rdy_i,
    output logic [W-1:0] rd_dat_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push, pop;

    assign full_o   = (cnt_q == (AW+1)'(DEPTH));
    assign rd_vld_o = (cnt_q != '0);
    assign rd_dat_o = mem_q[rd_ptr_q];
    assign push     = wr_vld_i && !full_o;
    assign pop      = rd_vld_o && rd_rdy_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == AW'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == AW'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (push) begin
                mem_q[wr_ptr_q] <= wr_dat_i;
            end
        end
    end
endmodule

module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    parameter int CNT_W = 16
) (
    input logic           clk,
    input logic           rst_n,
    imm_gen_pipe_if.slave bus
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [31:0]      ins;
    logic [31:0]      sx32;
    entry_t           dec_dat;
    entry_t           head_dat;
    logic             fifo_full;
    logic             in_fire;
    logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;

    assign ins = bus.instruction;

    // Every format is first built as a 32-bit sign-extended value, then widened
    // by replicating bit 31, so U at XLEN=64 gets the same treatment as the rest.
    always_comb begin
        sx32    = '0;
        dec_dat = '0;
        dec_dat.tag = bus.in_tag;
        case (ins[6:0])
            OP_LOAD, OP_OPIMM, OP_JALR, OP_SYSTEM: begin
                dec_dat.fmt = FMT_I;
                sx32 = {{20{ins[31]}}, ins[31:20]};
            end
            OP_STORE: begin
                dec_dat.fmt = FMT_S;
                sx32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            end
            OP_BRANCH: begin
                dec_dat.fmt = FMT_B;
                sx32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                dec_dat.fmt = FMT_U;
                sx32 = {ins[31:12], 12'b0};
            end
            OP_JAL: begin
                dec_dat.fmt = FMT_J;
                sx32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            OP_OP: begin
                dec_dat.fmt = FMT_R;
            end
            default: begin
                dec_dat.fmt     = FMT_ILL;
                dec_dat.illegal = 1'b1;
            end
        endcase
        dec_dat.imm       = {XLEN{sx32[31]}};
        dec_dat.imm[31:0] = sx32;
    end

    imm_gen_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (2)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_vld_i (in_fire),
        .wr_dat_i (dec_dat),
        .full_o   (fifo_full),
        .rd_vld_o (bus.out_valid),
        .rd_rdy_i (bus.out_ready),
        .rd_dat_o (head_dat)
    );

    // rst_n gating keeps in_ready low throughout reset and high right after release.
    assign bus.in_ready = rst_n && !fifo_full;
    assign in_fire      = bus.in_valid && bus.in_ready;

    assign bus.imm     = head_dat.imm;
    assign bus.fmt     = head_dat.fmt;
    assign bus.illegal = head_dat.illegal;
    assign bus.out_tag = head_dat.tag;

    always_comb begin
        ill_cnt_d = ill_cnt_q;
        if (in_fire && dec_dat.illegal && (ill_cnt_q != '1)) begin
            ill_cnt_d = ill_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ill_cnt_q <= '0;
        end else begin
            ill_cnt_q <= ill_cnt_d;
        end
    end

    assign bus.illegal_cnt = ill_cnt_q;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Drives two instances (XLEN=32/CNT_W=16 and XLEN=64/CNT_W=2) with identical stimulus
// and compares both against a queue-based reference model every cycle.
module tb_imm_gen_pipe;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] instruction;
    logic [4:0]  in_tag;
    logic        out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(5), .CNT_W(16)) ifa ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(5), .CNT_W(2))  ifb ();

    assign ifa.in_valid    = in_valid;
    assign ifa.instruction = instruction;
    assign ifa.in_tag      = in_tag;
    assign ifa.out_ready   = out_ready;
    assign ifb.in_valid    = in_valid;
    assign ifb.instruction = instruction;
    assign ifb.in_tag      = in_tag;
    assign ifb.out_ready   = out_ready;

    imm_gen_pipe #(.XLEN(32), .TAG_W(5), .CNT_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    imm_gen_pipe #(.XLEN(64), .TAG_W(5), .CNT_W(2))  dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [4:0]  tag;
    } exp_t;

    exp_t mq[$];
    int   cnt_a;
    int   cnt_b;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t ref_dec(input logic [31:0] i, input logic [4:0] t);
        exp_t   e;
        longint v;
        v     = 0;
        e.fmt = 3'd0;
        e.ill = 1'b0;
        e.tag = t;
        case (i[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: begin e.fmt = 3'd1; v = $signed(i[31:20]); end
            7'h23: begin e.fmt = 3'd2; v = $signed({i[31:25], i[11:7]}); end
            7'h63: begin e.fmt = 3'd3; v = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0}); end
            7'h37, 7'h17: begin e.fmt = 3'd4; v = $signed({i[31:12], 12'h000}); end
            7'h6F: begin e.fmt = 3'd5; v = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0}); end
            7'h33: e.fmt = 3'd0;
            default: begin e.fmt = 3'd7; e.ill = 1'b1; end
        endcase
        e.imm = v;
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [6:0]  op;
        logic [6:0]  ops [10] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
        int          k;
        r = $urandom;
        k = $urandom_range(0, 11);
        op = (k < 10) ? ops[k] : r[6:0];
        return {r[31:7], op};
    endfunction

    task automatic check_outputs(input string p);
        chk({p, "_a_in_ready"},  ifa.in_ready,  mq.size() < 2);
        chk({p, "_b_in_ready"},  ifb.in_ready,  mq.size() < 2);
        chk({p, "_a_out_valid"}, ifa.out_valid, mq.size() > 0);
        chk({p, "_b_out_valid"}, ifb.out_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            chk({p, "_a_imm"},  ifa.imm,     {32'h0, mq[0].imm[31:0]});
            chk({p, "_b_imm"},  ifb.imm,     mq[0].imm);
            chk({p, "_a_fmt"},  ifa.fmt,     mq[0].fmt);
            chk({p, "_b_fmt"},  ifb.fmt,     mq[0].fmt);
            chk({p, "_a_ill"},  ifa.illegal, mq[0].ill);
            chk({p, "_b_ill"},  ifb.illegal, mq[0].ill);
            chk({p, "_a_tag"},  ifa.out_tag, mq[0].tag);
            chk({p, "_b_tag"},  ifb.out_tag, mq[0].tag);
        end
        chk({p, "_a_cnt"}, ifa.illegal_cnt, cnt_a);
        chk({p, "_b_cnt"}, ifb.illegal_cnt, cnt_b);
    endtask

    // One clock: decide push/pop from the pre-edge model state, advance, then compare.
    task automatic cycle(input string p);
        bit   push;
        bit   pop;
        exp_t e;
        push = in_valid && (mq.size() < 2);
        pop  = out_ready && (mq.size() > 0);
        e    = ref_dec(instruction, in_tag);
        @(posedge clk);
        #1;
        if (pop) void'(mq.pop_front());
        if (push) begin
            mq.push_back(e);
            if (e.ill) begin
                if (cnt_a < 65535) cnt_a++;
                if (cnt_b < 3)     cnt_b++;
            end
        end
        check_outputs(p);
    endtask

    task automatic check_reset(input string p);
        chk({p, "_a_in_ready"},  ifa.in_ready,    1'b0);
        chk({p, "_b_in_ready"},  ifb.in_ready,    1'b0);
        chk({p, "_a_out_valid"}, ifa.out_valid,   1'b0);
        chk({p, "_b_out_valid"}, ifb.out_valid,   1'b0);
        chk({p, "_a_imm"},       ifa.imm,         '0);
        chk({p, "_b_imm"},       ifb.imm,         '0);
        chk({p, "_a_fmt"},       ifa.fmt,         '0);
        chk({p, "_a_ill"},       ifa.illegal,     '0);
        chk({p, "_a_tag"},       ifa.out_tag,     '0);
        chk({p, "_a_cnt"},       ifa.illegal_cnt, '0);
        chk({p, "_b_cnt"},       ifb.illegal_cnt, '0);
    endtask

    task automatic model_reset();
        mq.delete();
        cnt_a = 0;
        cnt_b = 0;
    endtask

    logic [31:0] vec_in  [5] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h123450B7, 32'h0010006F};
    logic [31:0] vec_imm [5] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000, 32'h00000800};
    logic [2:0]  vec_fmt [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        instruction = '0;
        in_tag      = '0;
        out_ready   = 1'b0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check_reset("rst");
        rst_n = 1'b1;
        #1;
        chk("rel_a_in_ready", ifa.in_ready, 1'b1);
        chk("rel_b_in_ready", ifb.in_ready, 1'b1);

        // Format vectors, each visible the cycle after acceptance.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            instruction = vec_in[k];
            in_tag      = 5'(k + 1);
            cycle("vec");
            chk($sformatf("vec%0d_imm", k), ifa.imm, vec_imm[k]);
            chk($sformatf("vec%0d_fmt", k), ifa.fmt, vec_fmt[k]);
        end

        // Illegal opcode path and counter saturation on the CNT_W=2 instance.
        chk("ill_cnt_before", ifa.illegal_cnt, 16'd0);
        instruction = 32'h0000007F;
        in_tag      = 5'd9;
        cycle("ill");
        chk("ill_fmt",   ifa.fmt,         3'd7);
        chk("ill_flag",  ifa.illegal,     1'b1);
        chk("ill_imm",   ifa.imm,         32'h0);
        chk("ill_cnt1",  ifa.illegal_cnt, 16'd1);
        repeat (4) cycle("ill_more");
        chk("ill_cnt_a5",  ifa.illegal_cnt, 16'd5);
        chk("ill_cnt_sat", ifb.illegal_cnt, 2'd3);

        // 64-bit sign extension.
        instruction = 32'hFFF00093;
        cycle("x64");
        chk("x64_i", ifb.imm, 64'hFFFFFFFFFFFFFFFF);
        instruction = 32'h800000B7;
        cycle("x64");
        chk("x64_u", ifb.imm, 64'hFFFFFFFF80000000);

        in_valid = 1'b0;
        repeat (2) cycle("drain");

        // Backpressure: third push must stall until a slot frees.
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        instruction = 32'h00000013;
        in_tag      = 5'd1;
        cycle("bp");
        in_tag = 5'd2;
        cycle("bp");
        chk("bp_full_in_ready", ifa.in_ready, 1'b0);
        in_tag = 5'd3;
        cycle("bp");
        chk("bp_head1", ifa.out_tag, 5'd1);
        out_ready = 1'b1;
        cycle("bp");
        chk("bp_head2", ifa.out_tag, 5'd2);
        chk("bp_ready_back", ifa.in_ready, 1'b1);
        cycle("bp");
        chk("bp_head3", ifa.out_tag, 5'd3);
        in_valid = 1'b0;
        cycle("bp");
        chk("bp_empty", ifa.out_valid, 1'b0);

        // Streaming at full rate: occupancy stays at one.
        in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            instruction = rand_inst();
            in_tag      = 5'(k + 8);
            cycle("stream");
            chk($sformatf("stream%0d_tag", k), ifa.out_tag, 5'(k + 8));
            chk($sformatf("stream%0d_rdy", k), ifa.in_ready, 1'b1);
        end
        in_valid = 1'b0;
        cycle("stream_end");

        // Random traffic with random backpressure.
        for (int k = 0; k < 300; k++) begin
            in_valid    = 1'($urandom_range(0, 1));
            out_ready   = ($urandom_range(0, 3) != 0);
            instruction = rand_inst();
            in_tag      = 5'($urandom_range(0, 31));
            cycle("rnd");
        end

        // Reset with both entries buffered.
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) cycle("pre_mid");
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        instruction = 32'h0000007F;
        repeat (2) cycle("mid_fill");
        chk("mid_full", ifa.in_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset("mid_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        #1;
        chk("mid_rel_a_in_ready", ifa.in_ready, 1'b1);
        chk("mid_rel_b_in_ready", ifb.in_ready, 1'b1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) cycle("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
